// File: rtl/fp_exe_ctrl_pkg.sv
// Types and constants for the FP execute request controller.
// Build option FP_EXE_TIMEOUT_EN enables the div/sqrt watchdog.
package fp_exe_ctrl_pkg;

  typedef struct packed {
    logic fmadd;
    logic fmsub;
    logic fnmsub;
    logic fnmadd;
    logic fadd;
    logic fsub;
    logic fmul;
    logic fdiv;
    logic fsqrt;
    logic fsgnj;
    logic fcmp;
    logic fmax;
    logic fclass;
    logic fmv_i2f;
    logic fmv_f2i;
    logic fcvt_i2f;
    logic fcvt_f2i;
    logic fcvt_f2f;
  } fp_operation_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PIPE    = 2'd1,
    DIVSQRT = 2'd2,
    RESPOND = 2'd3
  } fp_exe_ctrl_state_type;

  localparam logic [63:0] FP_CANON_NAN_S = 64'h0000_0000_7FC0_0000;
  localparam logic [63:0] FP_CANON_NAN_D = 64'h7FF8_0000_0000_0000;
  localparam logic [4:0]  FP_FLAG_NV     = 5'b10000;

  typedef struct packed {
    fp_exe_ctrl_state_type state;
    logic [3:0]            cnt;
    logic [63:0]           data1;
    logic [63:0]           data2;
    logic [63:0]           data3;
    logic [1:0]            fmt;
    logic [2:0]            rm;
    fp_operation_type      op;
    logic                  pipe_enable;
    logic                  divsqrt_start;
    logic                  divsqrt_sqrt;
    logic [63:0]           result;
    logic [4:0]            flags;
    logic                  drop;
    logic                  timeout_err;
  } fp_exe_ctrl_reg_type;

  function automatic logic [63:0] fp_canon_nan(input logic [1:0] fmt);
    return (fmt == 2'd1) ? FP_CANON_NAN_D : FP_CANON_NAN_S;
  endfunction

endpackage

// File: rtl/fp_exe_ctrl_if.sv
// Single-cycle request / registered response bundle between an FP initiator
// and fp_exe_ctrl.
interface fp_exe_ctrl_if;
  import fp_exe_ctrl_pkg::*;

  logic             req_enable;
  logic [63:0]      req_data1;
  logic [63:0]      req_data2;
  logic [63:0]      req_data3;
  logic [1:0]       req_fmt;
  logic [2:0]       req_rm;
  fp_operation_type req_op;
  logic             resp_ready;
  logic [63:0]      resp_result;
  logic [4:0]       resp_flags;

  modport master (
    output req_enable, req_data1, req_data2, req_data3, req_fmt, req_rm, req_op,
    input  resp_ready, resp_result, resp_flags
  );

  modport slave (
    input  req_enable, req_data1, req_data2, req_data3, req_fmt, req_rm, req_op,
    output resp_ready, resp_result, resp_flags
  );
endinterface

// File: rtl/fp_exe_ctrl_watchdog.sv
// Down-counting watchdog for the div/sqrt wait: reloads while idle, expires
// after TIMEOUT enabled cycles.
module fp_exe_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= W'(TIMEOUT - 1);
    else if (i_en && (r_cnt != '0))
      r_cnt <= r_cnt - W'(1);
  end

  assign o_expire = i_en && !i_load && (r_cnt == '0);
endmodule

// File: rtl/fp_exe_ctrl.sv
// Responder-side FP execute controller: routes a request to the fixed-latency
// pipe or the div/sqrt engine and returns one registered ready pulse.
// Optional div/sqrt watchdog and timeout_err port under FP_EXE_TIMEOUT_EN.
module fp_exe_ctrl
  import fp_exe_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  fp_exe_ctrl_if.slave      fp_exe,
  output logic              busy,
  output logic              req_drop,
  output logic              pipe_enable,
  output logic [63:0]       pipe_data1,
  output logic [63:0]       pipe_data2,
  output logic [63:0]       pipe_data3,
  output logic [1:0]        pipe_fmt,
  output logic [2:0]        pipe_rm,
  output fp_operation_type  pipe_op,
  input  logic [63:0]       pipe_result,
  input  logic [4:0]        pipe_flags,
  output logic              divsqrt_start,
  output logic              divsqrt_sqrt,
  input  logic              divsqrt_ready,
  input  logic [63:0]       divsqrt_result,
  input  logic [4:0]        divsqrt_flags
`ifdef FP_EXE_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  if (PIPE_LAT < 1 || PIPE_LAT > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("fp_exe_ctrl: PIPE_LAT must be 1..15 and TIMEOUT at least 1");
  end

  fp_exe_ctrl_reg_type r_q;
  fp_exe_ctrl_reg_type w_d;
  logic                w_expire;

`ifdef FP_EXE_TIMEOUT_EN
  fp_exe_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .i_load   (r_q.state != DIVSQRT),
    .i_en     (r_q.state == DIVSQRT),
    .o_expire (w_expire)
  );
  assign timeout_err = r_q.timeout_err;
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_d               = r_q;
    w_d.pipe_enable   = 1'b0;
    w_d.divsqrt_start = 1'b0;
    w_d.divsqrt_sqrt  = 1'b0;

    if (fp_exe.req_enable && (r_q.state != IDLE))
      w_d.drop = 1'b1;

    case (r_q.state)
      IDLE: begin
        if (fp_exe.req_enable) begin
          w_d.data1 = fp_exe.req_data1;
          w_d.data2 = fp_exe.req_data2;
          w_d.data3 = fp_exe.req_data3;
          w_d.fmt   = fp_exe.req_fmt;
          w_d.rm    = fp_exe.req_rm;
          w_d.op    = fp_exe.req_op;
          if (fp_exe.req_op.fdiv || fp_exe.req_op.fsqrt) begin
            w_d.state         = DIVSQRT;
            w_d.divsqrt_start = 1'b1;
            w_d.divsqrt_sqrt  = fp_exe.req_op.fsqrt;
          end else if (fp_exe.req_op != '0) begin
            w_d.state       = PIPE;
            w_d.pipe_enable = 1'b1;
            w_d.cnt         = 4'(PIPE_LAT - 1);
          end else begin
            w_d.state  = RESPOND;
            w_d.result = '0;
            w_d.flags  = '0;
          end
        end
      end
      PIPE: begin
        if (r_q.cnt == '0) begin
          w_d.state  = RESPOND;
          w_d.result = pipe_result;
          w_d.flags  = pipe_flags;
        end else begin
          w_d.cnt = r_q.cnt - 4'd1;
        end
      end
      DIVSQRT: begin
        // A same-edge engine completion wins over the watchdog.
        if (divsqrt_ready) begin
          w_d.state  = RESPOND;
          w_d.result = divsqrt_result;
          w_d.flags  = divsqrt_flags;
        end else if (w_expire) begin
          w_d.state       = RESPOND;
          w_d.result      = fp_canon_nan(r_q.fmt);
          w_d.flags       = FP_FLAG_NV;
          w_d.timeout_err = 1'b1;
        end
      end
      RESPOND: w_d.state = IDLE;
      default: w_d.state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)
      r_q <= '0;
    else
      r_q <= w_d;
  end

  assign busy               = (r_q.state != IDLE);
  assign req_drop           = r_q.drop;
  assign fp_exe.resp_ready  = (r_q.state == RESPOND);
  assign fp_exe.resp_result = r_q.result;
  assign fp_exe.resp_flags  = r_q.flags;
  assign pipe_enable        = r_q.pipe_enable;
  assign pipe_data1         = r_q.data1;
  assign pipe_data2         = r_q.data2;
  assign pipe_data3         = r_q.data3;
  assign pipe_fmt           = r_q.fmt;
  assign pipe_rm            = r_q.rm;
  assign pipe_op            = r_q.op;
  assign divsqrt_start      = r_q.divsqrt_start;
  assign divsqrt_sqrt       = r_q.divsqrt_sqrt;
endmodule
